// File: rtl/cw305_ml_pkg.sv
// Shared definitions for the CW305 ML multiply-accumulate register block:
// register map addresses and the engine state encoding.
package cw305_ml_pkg;

    localparam logic [31:0] REG_ML_INPUTS  = 32'h04;
    localparam logic [31:0] REG_ML_WEIGHTS = 32'h05;
    localparam logic [31:0] REG_ML_BIAS    = 32'h06;
    localparam logic [31:0] REG_ML_OUTPUTS = 32'h07;
    localparam logic [31:0] REG_ML_CTRL    = 32'h08;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BIAS,
        ST_MAC,
        ST_ACT
    } ml_state_e;

endpackage

// File: rtl/cw305_ml_mac_engine.sv
// Sequential MAC engine: one neuron at a time, bias load, pINPUTCNT
// multiply-accumulate steps, then a sign test that produces y[n].
// Handshake: a one-cycle go pulse is accepted only in IDLE; busy is high
// from the cycle after acceptance until the final ACT, and done rises
// in the same cycle busy falls, holding until the next accepted go.
module cw305_ml_mac_engine
    import cw305_ml_pkg::*;
#(
    parameter int pINPUTCNT  = 4,
    parameter int pOUTPUTCNT = 4,
    parameter int pDATA_W    = 8,
    parameter int pACC_W     = 24
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    go,
    input  logic [pINPUTCNT*pDATA_W-1:0]            x_flat,
    input  logic [pOUTPUTCNT*pINPUTCNT*pDATA_W-1:0] w_flat,
    input  logic [pOUTPUTCNT*16-1:0]                bias_flat,
    output logic [pOUTPUTCNT-1:0]                   y,
    output logic                                    busy,
    output logic                                    done,
    output ml_state_e                               state
);

    localparam int IW = (pINPUTCNT  > 1) ? $clog2(pINPUTCNT)  : 1;
    localparam int NW = (pOUTPUTCNT > 1) ? $clog2(pOUTPUTCNT) : 1;
    localparam logic [IW-1:0] I_LAST = IW'(pINPUTCNT - 1);
    localparam logic [NW-1:0] N_LAST = NW'(pOUTPUTCNT - 1);

    logic [IW-1:0]               i;
    logic [NW-1:0]               n;
    logic signed [pACC_W-1:0]    acc;
    logic signed [pDATA_W-1:0]   x_cur;
    logic signed [pDATA_W-1:0]   w_cur;
    logic signed [15:0]          bias_cur;
    logic signed [2*pDATA_W-1:0] prod;

    // Select the current operands and form the full-width signed product.
    always_comb begin
        x_cur    = x_flat[pDATA_W*int'(i) +: pDATA_W];
        w_cur    = w_flat[pDATA_W*(int'(n)*pINPUTCNT + int'(i)) +: pDATA_W];
        bias_cur = bias_flat[16*int'(n) +: 16];
        prod     = (2*pDATA_W)'(x_cur) * (2*pDATA_W)'(w_cur);
    end

    // Engine FSM with counters, accumulator and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            i     <= '0;
            n     <= '0;
            acc   <= '0;
            y     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (go) begin
                        state <= ST_BIAS;
                        y     <= '0;
                        done  <= 1'b0;
                        busy  <= 1'b1;
                        n     <= '0;
                    end
                end
                ST_BIAS: begin
                    acc   <= pACC_W'(bias_cur);
                    i     <= '0;
                    state <= ST_MAC;
                end
                ST_MAC: begin
                    acc <= acc + pACC_W'(prod);
                    if (i == I_LAST) begin
                        state <= ST_ACT;
                    end else begin
                        i <= i + 1'b1;
                    end
                end
                ST_ACT: begin
                    // Strictly positive gives 1; zero and negative give 0.
                    y[n] <= ~acc[pACC_W-1] & (|acc);
                    if (n == N_LAST) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        n     <= n + 1'b1;
                        state <= ST_BIAS;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/cw305_reg_ml_mac.sv
// USB register front end for the ML MAC engine: holds inputs, weights and
// biases, decodes writes, starts runs from CTRL and drives a registered
// read byte. Parameter writes are dropped while the engine is running.
module cw305_reg_ml_mac
    import cw305_ml_pkg::*;
#(
    parameter int pADDR_WIDTH   = 21,
    parameter int pBYTECNT_SIZE = 7,
    parameter int pINPUTCNT     = 4,
    parameter int pOUTPUTCNT    = 4,
    parameter int pDATA_W       = 8,
    parameter int pACC_W        = 24
) (
    input  logic                                 usb_clk,
    input  logic                                 reset_i,
    input  logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0] reg_address,
    input  logic [pBYTECNT_SIZE-1:0]             reg_bytecnt,
    input  logic [7:0]                           write_data,
    output logic [7:0]                           read_data,
    input  logic                                 reg_read,
    input  logic                                 reg_write,
    input  logic                                 reg_addrvalid,
    output logic                                 busy_o,
    output logic                                 done_o
);

    localparam int NW_BYTES = pOUTPUTCNT * pINPUTCNT;
    localparam int NB_BYTES = 2 * pOUTPUTCNT;
    localparam int NY_BYTES = (pOUTPUTCNT + 7) / 8;

    logic [pINPUTCNT-1:0][pDATA_W-1:0] x_reg;
    logic [NW_BYTES-1:0][pDATA_W-1:0]  w_reg;
    logic [NB_BYTES-1:0][7:0]          bias_reg;
    logic [pOUTPUTCNT-1:0]             y;
    logic [NY_BYTES*8-1:0]             y_pad;
    ml_state_e                         eng_state;
    logic [31:0]                       addr;
    logic [31:0]                       byte_idx;
    logic                              wr_en;
    logic                              idle;
    logic                              go;
    logic [7:0]                        rd_byte;

    assign addr     = 32'(reg_address);
    assign byte_idx = 32'(reg_bytecnt);
    assign wr_en    = reg_write & reg_addrvalid;
    assign idle     = (eng_state == ST_IDLE);
    assign go       = wr_en && (addr == REG_ML_CTRL) && (byte_idx == 0) && write_data[0];
    assign y_pad    = (NY_BYTES*8)'(y);

    // Parameter register writes; out-of-range bytes simply match nothing.
    always_ff @(posedge usb_clk) begin
        if (reset_i) begin
            x_reg    <= '0;
            w_reg    <= '0;
            bias_reg <= '0;
        end else if (wr_en && idle) begin
            for (int b = 0; b < pINPUTCNT; b++)
                if (addr == REG_ML_INPUTS && byte_idx == 32'(b)) x_reg[b] <= write_data;
            for (int b = 0; b < NW_BYTES; b++)
                if (addr == REG_ML_WEIGHTS && byte_idx == 32'(b)) w_reg[b] <= write_data;
            for (int b = 0; b < NB_BYTES; b++)
                if (addr == REG_ML_BIAS && byte_idx == 32'(b)) bias_reg[b] <= write_data;
        end
    end

    // Read mux; unmapped addresses and out-of-range bytes return zero.
    always_comb begin
        rd_byte = '0;
        case (addr)
            REG_ML_INPUTS:
                for (int b = 0; b < pINPUTCNT; b++)
                    if (byte_idx == 32'(b)) rd_byte = x_reg[b];
            REG_ML_WEIGHTS:
                for (int b = 0; b < NW_BYTES; b++)
                    if (byte_idx == 32'(b)) rd_byte = w_reg[b];
            REG_ML_BIAS:
                for (int b = 0; b < NB_BYTES; b++)
                    if (byte_idx == 32'(b)) rd_byte = bias_reg[b];
            REG_ML_OUTPUTS:
                for (int k = 0; k < NY_BYTES; k++)
                    if (byte_idx == 32'(k)) rd_byte = y_pad[8*k +: 8];
            REG_ML_CTRL:
                if (byte_idx == 0) rd_byte = {6'b0, done_o, busy_o};
            default: rd_byte = '0;
        endcase
    end

    // Registered read byte, updated only on a qualified read.
    always_ff @(posedge usb_clk) begin
        if (reset_i) begin
            read_data <= '0;
        end else if (reg_read && reg_addrvalid) begin
            read_data <= rd_byte;
        end
    end

    cw305_ml_mac_engine #(
        .pINPUTCNT (pINPUTCNT),
        .pOUTPUTCNT(pOUTPUTCNT),
        .pDATA_W   (pDATA_W),
        .pACC_W    (pACC_W)
    ) u_engine (
        .clk      (usb_clk),
        .rst      (reset_i),
        .go       (go),
        .x_flat   (x_reg),
        .w_flat   (w_reg),
        .bias_flat(bias_reg),
        .y        (y),
        .busy     (busy_o),
        .done     (done_o),
        .state    (eng_state)
    );

endmodule

// File: doc/cw305_reg_ml_mac.md
# cw305_reg_ml_mac

Parametrised USB-register front end plus sequential multiply-accumulate engine for the CW305 ML target. It generalises the single-layer perceptron register block to pOUTPUTCNT neurons of pINPUTCNT signed multi-bit inputs each, with multi-byte register access via `reg_bytecnt`. It adds a go/busy/done handshake, so inference runs as a timed, observable sequence rather than combinationally. It sits on the `usb_clk` register bus alongside the other `cw305_reg_*` blocks.

## Interface
- pADDR_WIDTH, 21, full register-bus address width.
- pBYTECNT_SIZE, 7, byte-index width; register select is `reg_address` (pADDR_WIDTH-pBYTECNT_SIZE bits).
- pINPUTCNT, 4, inputs per neuron (≥1).
- pOUTPUTCNT, 4, neuron count (≥1).
- pDATA_W, 8, signed input/weight width, fixed at 8 (one byte per element).
- pACC_W, 24, signed accumulator width (≥16).
- usb_clk  in  1  sole clock.
- reset_i  in  1  reset; **one clock; reset is synchronous and active-high.**
- reg_address  in  pADDR_WIDTH-pBYTECNT_SIZE  register select.
- reg_bytecnt  in  pBYTECNT_SIZE  byte index within register.
- write_data  in  8  write byte.
- read_data  out  8  registered read byte.
- reg_read  in  1  read strobe.
- reg_write  in  1  write strobe.
- reg_addrvalid  in  1  qualifies address/bytecnt.
- busy_o  out  1  engine running.
- done_o  out  1  last run completed.

## Operation
- Registers (byte index b):
  - 0x04 INPUTS: byte b = x[b], b<pINPUTCNT.
  - 0x05 WEIGHTS: byte n*pINPUTCNT+i = w[n][i].
  - 0x06 BIAS: bytes 2n and 2n+1 = bias[n], 16-bit signed, little-endian; sign-extended to pACC_W.
  - 0x07 OUTPUTS: read-only, byte k bit j = y[8k+j].
  - 0x08 CTRL: write with bit0=1 starts a run; read returns {6'b0, done, busy}.
- Write accepted on a rising edge with reg_write & reg_addrvalid. Writes to 0x04–0x06 are dropped while busy. Out-of-range byte index: write ignored, read 0. Unmapped address reads 0.
- FSM states: IDLE, BIAS, MAC, ACT.
  - IDLE→BIAS on accepted go; clears y, clears done, sets n=0.
  - BIAS (1 cycle): acc=sext(bias[n]), i=0.
  - MAC (pINPUTCNT cycles): acc += x[i]*w[n][i]; i++.
  - ACT (1 cycle): y[n] = (acc > 0, signed); zero gives 0. If n==pOUTPUTCNT-1, go to IDLE and set done; else n++ and go to BIAS.
- Arithmetic: 8×8 signed product is 16-bit and sign-extended. Accumulation wraps modulo 2^pACC_W; no saturation.
- Go while busy: ignored.
- Reset, including mid-run: FSM→IDLE; all inputs, weights, biases, y, acc, busy, done and read_data cleared to 0.

## Timing
- A go accepted at edge E gives busy_o=1 from E+1 for exactly pOUTPUTCNT*(pINPUTCNT+2) cycles; defaults give 24.
- done_o rises in the same cycle busy_o falls. It holds until the next accepted go or reset.
- y[n] is visible at 0x07 the cycle after its ACT. Partial results are readable while busy.
- read_data is registered. When reg_read & reg_addrvalid at edge E, data for that address/bytecnt appears after E and holds until the next qualified read.
- Write-then-read of the same byte on consecutive edges returns the new value.

## Structure
- Package cw305_ml_pkg: register address constants (REG_ML_INPUTS..REG_ML_CTRL) and the FSM state enum.
- Sub-module cw305_ml_mac_engine: FSM, index counters, accumulator and y vector. It reads flattened x/w/bias arrays held in the register shell.
- Register decode and read mux live in the top module.

## Test plan
- Defaults; x={1,2,3,4}; all w=1; bias=0; go → busy high 24 cycles, then done=1; OUTPUTS byte0=0x0F; CTRL reads 0x02.
- As above, but w[0][*]=0xFF (−1) → acc0=−10; OUTPUTS=0x0E.
- All w=0; bias[2]=0x0001; others 0 → OUTPUTS=0x04, confirming zero→0.
- pACC_W=16; all x=0x80; all w=0x80 → sum 65536 wraps to 0; OUTPUTS=0x00.
- Go, then at busy cycle 5 write x[0]=0x7F and issue a second go → x[0] reads unchanged; busy still totals 24 cycles.
- reset_i pulsed at busy cycle 10 → next cycle busy=0, done=0, read of OUTPUTS and INPUTS byte0 returns 0x00.
